mips_control: RTL and testbench



---
 rtl/mips_control_pkg.sv | 57 +++++
 rtl/mips_control_if.sv | 44 ++++
 rtl/mips_control_alu_decode.sv | 34 +++
 rtl/mips_control.sv | 157 +++++++++++++++
 tb/tb_mips_control.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mips_control_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared opcode/funct encodings, ALU operation codes and PC-select
//          encodings for the MIPS-style control decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_BZ    = 6'h18;
  localparam logic [5:0] OPC_BN    = 6'h19;
  localparam logic [5:0] OPC_BALZ  = 6'h1A;
  localparam logic [5:0] OPC_BALN  = 6'h1B;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_JR    = 6'h08;
  localparam logic [5:0] FUNCT_JALR  = 6'h09;
  localparam logic [5:0] FUNCT_BRZ   = 6'h14;
  localparam logic [5:0] FUNCT_BRN   = 6'h15;
  localparam logic [5:0] FUNCT_BALRZ = 6'h16;
  localparam logic [5:0] FUNCT_BALRN = 6'h17;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_MEM    = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mips_control_if.sv
// ============================================================================
// Module : mips_control_if
// Brief  : Instruction in / datapath control out bundle of the decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mips_control_if;

  logic [31:0] instruction;
  logic        reg_write;
  logic        reg_dst;
  logic        write_reg31;
  logic        link;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic        ext_op;
  logic        mem_write;
  logic        mem_to_reg;
  logic        is_jump;
  logic        zero_branch;
  logic        need_zero;
  logic        status_branch;
  logic        need_st_Z;
  logic [1:0]  pc_select;
  logic        illegal_op;

  modport master (
    output instruction,
    input  reg_write, reg_dst, write_reg31, link, alu_src, alu_op, ext_op,
    input  mem_write, mem_to_reg, is_jump, zero_branch, need_zero,
    input  status_branch, need_st_Z, pc_select, illegal_op
  );

  modport slave (
    input  instruction,
    output reg_write, reg_dst, write_reg31, link, alu_src, alu_op, ext_op,
    output mem_write, mem_to_reg, is_jump, zero_branch, need_zero,
    output status_branch, need_st_Z, pc_select, illegal_op
  );

endinterface

`default_nettype wire

// File: rtl/mips_control_alu_decode.sv
// ============================================================================
// Module : alu_decode
// Brief  : Maps an R-type funct field to its ALU operation code.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = OP_ADD;
    valid  = 1'b1;
    case (funct)
      FUNCT_SLL: alu_op = OP_SLL;
      FUNCT_SRL: alu_op = OP_SRL;
      FUNCT_ADD: alu_op = OP_ADD;
      FUNCT_SUB: alu_op = OP_SUB;
      FUNCT_AND: alu_op = OP_AND;
      FUNCT_OR:  alu_op = OP_OR;
      FUNCT_NOR: alu_op = OP_NOR;
      FUNCT_SLT: alu_op = OP_SLT;
      default:   valid  = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_control.sv
// ============================================================================
// Module : mips_control
// Brief  : Single-cycle MIPS main decoder with sticky illegal-instruction flag.
//          Optional Z-status branches: define CONTROL_STATUS_BRANCH_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_control
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mips_control_if.slave bus
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [2:0] rtype_alu_op;
  logic       rtype_alu_valid;
  logic       decoded;
  logic       illegal_q;
  logic       unused_fields;

  assign opcode        = bus.instruction[31:26];
  assign funct         = bus.instruction[5:0];
  assign unused_fields = ^bus.instruction[25:6];

  alu_decode u_alu_decode (
    .funct  (funct),
    .alu_op (rtype_alu_op),
    .valid  (rtype_alu_valid)
  );

  always_comb begin
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.write_reg31   = 1'b0;
    bus.link          = 1'b0;
    bus.alu_src       = 1'b0;
    bus.alu_op        = OP_ADD;
    bus.ext_op        = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.is_jump       = 1'b0;
    bus.zero_branch   = 1'b0;
    bus.need_zero     = 1'b0;
    bus.status_branch = 1'b0;
    bus.need_st_Z     = 1'b0;
    bus.pc_select     = PC_SEQ;
    decoded           = 1'b1;

    case (opcode)
      OPC_RTYPE: begin
        if (rtype_alu_valid) begin
          bus.reg_write = 1'b1;
          bus.alu_op    = rtype_alu_op;
        end else begin
          case (funct)
            FUNCT_JR: begin
              bus.is_jump   = 1'b1;
              bus.pc_select = PC_RS;
            end
            FUNCT_JALR: begin
              bus.is_jump   = 1'b1;
              bus.pc_select = PC_RS;
              bus.reg_write = 1'b1;
              bus.link      = 1'b1;
            end
`ifdef CONTROL_STATUS_BRANCH_EN
            FUNCT_BRZ, FUNCT_BRN, FUNCT_BALRZ, FUNCT_BALRN: begin
              bus.status_branch = 1'b1;
              bus.need_st_Z     = ~funct[0];
              bus.pc_select     = PC_RS;
              // Bit 1 separates the linking variants (0x16/0x17).
              bus.reg_write     = funct[1];
              bus.link          = funct[1];
            end
`endif
            default: decoded = 1'b0;
          endcase
        end
      end
      OPC_ADDI: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        bus.alu_src   = 1'b1;
        bus.ext_op    = 1'b1;
      end
      OPC_ANDI: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        bus.alu_src   = 1'b1;
        bus.alu_op    = OP_AND;
      end
      OPC_ORI: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        bus.alu_src   = 1'b1;
        bus.alu_op    = OP_OR;
      end
      OPC_LW: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.alu_src    = 1'b1;
        bus.ext_op     = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      OPC_SW: begin
        bus.mem_write = 1'b1;
        bus.alu_src   = 1'b1;
        bus.ext_op    = 1'b1;
      end
      OPC_BEQ, OPC_BNE: begin
        bus.zero_branch = 1'b1;
        bus.need_zero   = (opcode == OPC_BEQ);
        bus.alu_op      = OP_SUB;
        bus.ext_op      = 1'b1;
      end
      OPC_J: begin
        bus.is_jump   = 1'b1;
        bus.pc_select = PC_TARGET;
      end
      OPC_JAL: begin
        bus.is_jump     = 1'b1;
        bus.pc_select   = PC_TARGET;
        bus.reg_write   = 1'b1;
        bus.link        = 1'b1;
        bus.write_reg31 = 1'b1;
      end
`ifdef CONTROL_STATUS_BRANCH_EN
      OPC_BZ, OPC_BN, OPC_BALZ, OPC_BALN: begin
        bus.status_branch = 1'b1;
        bus.need_st_Z     = ~opcode[0];
        bus.pc_select     = PC_TARGET;
        bus.reg_write     = opcode[1];
        bus.link          = opcode[1];
        bus.write_reg31   = opcode[1];
      end
`endif
      default: decoded = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (!decoded) begin
      illegal_q <= 1'b1;
    end
  end

  assign bus.illegal_op = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_control.sv
// ============================================================================
// Module : tb_mips_control
// Brief  : Vector-table bench for the MIPS control decoder and sticky flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_control;

  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;
    logic       write_reg31;
    logic       link;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       mem_write;
    logic       mem_to_reg;
    logic       is_jump;
    logic       zero_branch;
    logic       need_zero;
    logic       status_branch;
    logic       need_st_Z;
    logic [1:0] pc_select;
  } ctrl_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    ctrl_t       exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  mips_control_if bus ();

  mips_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctrl_t actual();
    ctrl_t c;
    c = '{reg_write: bus.reg_write, reg_dst: bus.reg_dst, write_reg31: bus.write_reg31,
          link: bus.link, alu_src: bus.alu_src, alu_op: bus.alu_op, ext_op: bus.ext_op,
          mem_write: bus.mem_write, mem_to_reg: bus.mem_to_reg, is_jump: bus.is_jump,
          zero_branch: bus.zero_branch, need_zero: bus.need_zero,
          status_branch: bus.status_branch, need_st_Z: bus.need_st_Z,
          pc_select: bus.pc_select};
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // Present one instruction, check decode, then check the flag after an edge.
  task automatic apply(input string name, input logic [31:0] instr, input ctrl_t exp,
                       input logic exp_illegal);
    @(negedge clk);
    bus.instruction = instr;
    #1;
    check({name, " ctrl"}, 32'(actual()), 32'(exp));
    @(posedge clk);
    #1;
    check({name, " illegal_op"}, 32'(bus.illegal_op), 32'(exp_illegal));
  endtask

  localparam ctrl_t DEF = '0;

  vec_t vecs[19];
  vec_t sb_vecs[8];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.instruction = 32'h0;

    vecs[0]  = '{"addi", 32'h2010FEFE, '{reg_write:1'b1, reg_dst:1'b1, alu_src:1'b1, ext_op:1'b1, default:'0}};
    vecs[1]  = '{"sll",  32'h00108400, '{reg_write:1'b1, alu_op:3'd6, default:'0}};
    vecs[2]  = '{"srl",  32'h00104042, '{reg_write:1'b1, alu_op:3'd7, default:'0}};
    vecs[3]  = '{"sub",  32'h02114022, '{reg_write:1'b1, alu_op:3'd1, default:'0}};
    vecs[4]  = '{"nor",  32'h02114027, '{reg_write:1'b1, alu_op:3'd4, default:'0}};
    vecs[5]  = '{"add",  32'h02114020, '{reg_write:1'b1, alu_op:3'd0, default:'0}};
    vecs[6]  = '{"and",  32'h02114024, '{reg_write:1'b1, alu_op:3'd2, default:'0}};
    vecs[7]  = '{"or",   32'h02114025, '{reg_write:1'b1, alu_op:3'd3, default:'0}};
    vecs[8]  = '{"slt",  32'h0211402A, '{reg_write:1'b1, alu_op:3'd5, default:'0}};
    vecs[9]  = '{"andi", 32'h320900CF, '{reg_write:1'b1, reg_dst:1'b1, alu_src:1'b1, alu_op:3'd2, default:'0}};
    vecs[10] = '{"ori",  32'h360900C0, '{reg_write:1'b1, reg_dst:1'b1, alu_src:1'b1, alu_op:3'd3, default:'0}};
    vecs[11] = '{"lw",   32'h8E090004, '{reg_write:1'b1, reg_dst:1'b1, alu_src:1'b1, ext_op:1'b1, mem_to_reg:1'b1, default:'0}};
    vecs[12] = '{"sw",   32'hAE090004, '{mem_write:1'b1, alu_src:1'b1, ext_op:1'b1, default:'0}};
    vecs[13] = '{"beq",  32'h11090003, '{zero_branch:1'b1, need_zero:1'b1, alu_op:3'd1, ext_op:1'b1, default:'0}};
    vecs[14] = '{"bne",  32'h15090003, '{zero_branch:1'b1, alu_op:3'd1, ext_op:1'b1, default:'0}};
    vecs[15] = '{"j",    32'h08000004, '{is_jump:1'b1, pc_select:2'b01, default:'0}};
    vecs[16] = '{"jal",  32'h0C000004, '{is_jump:1'b1, pc_select:2'b01, reg_write:1'b1, link:1'b1, write_reg31:1'b1, default:'0}};
    vecs[17] = '{"jr",   32'h03E00008, '{is_jump:1'b1, pc_select:2'b10, default:'0}};
    vecs[18] = '{"jalr", 32'h03E0F809, '{is_jump:1'b1, pc_select:2'b10, reg_write:1'b1, link:1'b1, default:'0}};

    sb_vecs[0] = '{"bz",    32'h60000004, '{status_branch:1'b1, need_st_Z:1'b1, pc_select:2'b01, default:'0}};
    sb_vecs[1] = '{"bn",    32'h64000004, '{status_branch:1'b1, pc_select:2'b01, default:'0}};
    sb_vecs[2] = '{"balz",  32'h68000004, '{status_branch:1'b1, need_st_Z:1'b1, pc_select:2'b01, reg_write:1'b1, link:1'b1, write_reg31:1'b1, default:'0}};
    sb_vecs[3] = '{"baln",  32'h6C000004, '{status_branch:1'b1, pc_select:2'b01, reg_write:1'b1, link:1'b1, write_reg31:1'b1, default:'0}};
    sb_vecs[4] = '{"brz",   32'h03E00014, '{status_branch:1'b1, need_st_Z:1'b1, pc_select:2'b10, default:'0}};
    sb_vecs[5] = '{"brn",   32'h03E00015, '{status_branch:1'b1, pc_select:2'b10, default:'0}};
    sb_vecs[6] = '{"balrz", 32'h03E0F816, '{status_branch:1'b1, need_st_Z:1'b1, pc_select:2'b10, reg_write:1'b1, link:1'b1, default:'0}};
    sb_vecs[7] = '{"balrn", 32'h03E0F817, '{status_branch:1'b1, pc_select:2'b10, reg_write:1'b1, link:1'b1, default:'0}};

    repeat (2) @(posedge clk);
    #1;
    check("reset illegal_op", 32'(bus.illegal_op), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) apply(vecs[i].name, vecs[i].instr, vecs[i].exp, 1'b0);

    // Undecoded opcode: defaults now, flag only after the edge.
    @(negedge clk);
    bus.instruction = 32'hFC000000;
    #1;
    check("op3F ctrl", 32'(actual()), 32'(DEF));
    check("op3F before edge", 32'(bus.illegal_op), 32'd0);
    @(posedge clk);
    #1;
    check("op3F after edge", 32'(bus.illegal_op), 32'd1);

    apply("sticky addi", 32'h2010FEFE, vecs[0].exp, 1'b1);

    // Asynchronous clear mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    check("async clear", 32'(bus.illegal_op), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("bad funct", 32'h0000003F, DEF, 1'b1);

    // Reset held across an edge with an illegal instruction present.
    @(negedge clk);
    rst_n = 1'b0;
    bus.instruction = 32'hFC000000;
    @(posedge clk);
    #1;
    check("reset wins", 32'(bus.illegal_op), 32'd0);
    @(negedge clk);
    bus.instruction = 32'h2010FEFE;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      pulse_reset();
`ifdef CONTROL_STATUS_BRANCH_EN
      apply(sb_vecs[i].name, sb_vecs[i].instr, sb_vecs[i].exp, 1'b0);
`else
      apply(sb_vecs[i].name, sb_vecs[i].instr, DEF, 1'b1);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
